wb_stream_reader_ctrl: RTL and testbench

- Stream-to-memory DMA master: drains a FWFT FIFO that is filled from an incoming stream, and burst-writes its contents over a Wishbone master port into a memory buffer.
- Direct inverse neighbour of the stream writer (memory-to-stream). Typical use: loopback or capture path downstream of a stream source.
- Configured by a cfg block supplying start_adr, buf_size, burst_size and enable; reports completion via a done pulse.

---
 rtl/wb_streamer_pkg.sv | 17 +
 rtl/wb_stream_burst_len.sv | 21 ++
 rtl/wb_stream_reader_ctrl.sv | 159 +++++++++++++++
 tb/tb_wb_stream_reader_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_streamer_pkg.sv
// Shared definitions for the Wishbone stream reader/writer controllers:
// FSM state encoding and Wishbone cycle-type / burst-type constants.
package wb_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_stream_burst_len.sv
// Burst length selection: min(burst_size, MAX_BURST_LEN, remaining), with a
// requested burst size of 0 treated as single-beat bursts.
module wb_stream_burst_len #(
    parameter int AW            = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [AW-1:0] burst_size_i,
    input  logic [AW-1:0] remaining_i,
    output logic [AW-1:0] blen_o
);

    logic [AW-1:0] req_len;
    logic [AW-1:0] clamp_len;

    always_comb begin
        req_len = (burst_size_i == '0) ? AW'(1) : burst_size_i;
        clamp_len = (req_len > AW'(MAX_BURST_LEN)) ? AW'(MAX_BURST_LEN) : req_len;
        blen_o = (clamp_len > remaining_i) ? remaining_i : clamp_len;
    end

endmodule

// File: rtl/wb_stream_reader_ctrl.sv
// Stream-to-memory DMA master: drains a FWFT FIFO into memory via Wishbone
// incrementing bursts. Define WB_STREAM_READER_CIRCULAR_EN for ring-buffer capture.
module wb_stream_reader_ctrl
    import wb_streamer_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    input  logic                 enable,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [WB_AW-1:0] ADR_INC = WB_AW'(WB_DW/8);

    state_e           state_q;
    logic [WB_AW-1:0] adr_q;
    logic [WB_AW-1:0] remaining_q;
    logic [WB_AW-1:0] beats_q;
    logic             cyc_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WB_AW-1:0] blen;
    logic [WB_AW-1:0] fifo_cnt_ext;
    logic             beat_ack;
    logic             last_beat;
    logic             unused_dat;

    wb_stream_burst_len #(
        .AW            (WB_AW),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_len (
        .burst_size_i (burst_size),
        .remaining_i  (remaining_q),
        .blen_o       (blen)
    );

    assign fifo_cnt_ext = WB_AW'(fifo_cnt);
    // err overrides ack and rty holds the beat, so only a clean ack consumes data
    assign beat_ack     = cyc_q & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
    assign last_beat    = (beats_q == WB_AW'(1));
    assign fifo_rd      = beat_ack & ~wb_rst_i;

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b1;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = !cyc_q ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INC);
    assign wbm_bte_o = BTE_LINEAR;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign unused_dat = ^wbm_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && buf_size != '0) begin
                        adr_q       <= start_adr;
                        remaining_q <= buf_size;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (fifo_cnt_ext >= blen) begin
                        cyc_q   <= 1'b1;
                        beats_q <= blen;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (wbm_err_i) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (beat_ack) begin
                        adr_q       <= adr_q + ADR_INC;
                        beats_q     <= beats_q - WB_AW'(1);
                        remaining_q <= remaining_q - WB_AW'(1);
                        if (last_beat) begin
                            cyc_q <= 1'b0;
                            if (remaining_q == WB_AW'(1)) begin
                                done_q <= 1'b1;
`ifdef WB_STREAM_READER_CIRCULAR_EN
                                if (enable && buf_size != '0) begin
                                    adr_q       <= start_adr;
                                    remaining_q <= buf_size;
                                    state_q     <= ST_WAIT;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
`else
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
`endif
                            end else if (!enable) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Scoreboard bench for wb_stream_reader_ctrl: FIFO model, Wishbone slave with
// rty/err injection, per-beat address/data/cti checking.
module tb_wb_stream_reader_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int FAW = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } exp_t;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic            wbm_we_o;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic [2:0]      wbm_cti_o;
    logic [1:0]      wbm_bte_o;
    logic [DW-1:0]   wbm_dat_i = '0;
    logic            wbm_ack_i = 1'b0;
    logic            wbm_err_i = 1'b0;
    logic            wbm_rty_i = 1'b0;
    logic [DW-1:0]   fifo_d = '0;
    logic            fifo_rd;
    logic [FAW:0]    fifo_cnt = '0;
    logic [AW-1:0]   start_adr = '0;
    logic [AW-1:0]   buf_size = '0;
    logic [AW-1:0]   burst_size = '0;
    logic            enable = 1'b0;
    logic            busy;
    logic            done;
    logic            err;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_stream_reader_ctrl #(
        .WB_AW   (AW),
        .WB_DW   (DW),
        .FIFO_AW (FAW)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cti_o  (wbm_cti_o),
        .wbm_bte_o  (wbm_bte_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .wbm_rty_i  (wbm_rty_i),
        .fifo_d     (fifo_d),
        .fifo_rd    (fifo_rd),
        .fifo_cnt   (fifo_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          attempt  = 0;
    int          rty_at   = 0;
    int          err_at   = 0;
    int          n_pops   = 0;
    bit          ack_en   = 1'b1;
    bit          pop_pending = 1'b0;
    logic [31:0] fifo_q[$];
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem [logic [31:0]];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic fifo_update();
        fifo_d   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        fifo_cnt = 5'(fifo_q.size());
    endtask

    task automatic fifo_push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_update();
    endtask

    // FIFO pop lands just after the edge so the DUT never races a changing fifo_cnt
    always @(posedge wb_clk_i) begin
        #1;
        if (pop_pending) begin
            if (fifo_q.size() == 0) check_eq("fifo_underflow", 1, 0);
            else void'(fifo_q.pop_front());
            fifo_update();
        end
    end

    // Wishbone slave: decides this cycle's response, then checks the beat
    always @(negedge wb_clk_i) begin
        wbm_ack_i = 1'b0;
        wbm_rty_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !wb_rst_i) begin
            attempt++;
            if (attempt == err_at)      wbm_err_i = 1'b1;
            else if (attempt == rty_at) wbm_rty_i = 1'b1;
            else if (ack_en)            wbm_ack_i = 1'b1;
        end
        #1;
        pop_pending = fifo_rd;
        if (fifo_rd) n_pops++;
        if (wbm_ack_i) begin
            check_eq("pop_on_ack", fifo_rd, 1);
            if (sb.size() == 0) begin
                check_eq("sb_extra_beat", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("beat adr=%08h dat=%08h cti=%03b", wbm_adr_o, wbm_dat_o, wbm_cti_o);
                check_eq("beat_adr", wbm_adr_o, mon_e.adr);
                check_eq("beat_dat", wbm_dat_o, mon_e.dat);
                check_eq("beat_cti", wbm_cti_o, mon_e.cti);
                mem[wbm_adr_o] = wbm_dat_o;
            end
        end else if (wbm_rty_i) begin
            $display("retry adr=%08h", wbm_adr_o);
            check_eq("pop_on_rty", fifo_rd, 0);
            if (sb.size() != 0) begin
                check_eq("rty_adr_held", wbm_adr_o, sb[0].adr);
                check_eq("rty_dat_held", wbm_dat_o, sb[0].dat);
            end
        end else if (wbm_err_i) begin
            $display("error adr=%08h", wbm_adr_o);
            check_eq("pop_on_err", fifo_rd, 0);
        end else if (fifo_rd) begin
            check_eq("spurious_pop", 1, 0);
        end
    end

    task automatic run_xfer(input logic [31:0] sa, input int bufsz, input int bs,
                            input int nwords, input bit trickle, input int exp_done,
                            input int exp_pops, input int rty_k, input int err_k);
        logic [31:0] words[$];
        logic [31:0] w;
        int          bsz;
        int          j;
        int          dones = 0;
        int          pushed = 0;
        bit          finished = 1'b0;
        bit          prev_cyc = 1'b0;
        attempt = 0;
        rty_at  = rty_k;
        err_at  = err_k;
        n_pops  = 0;
        bsz = (bs == 0) ? 1 : ((bs > 16) ? 16 : bs);
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            words.push_back(w);
            j = i % bufsz;
            sb.push_back('{adr: sa + 32'(4 * j), dat: w,
                           cti: ((j % bsz == bsz - 1) || (j == bufsz - 1)) ? 3'b111 : 3'b010});
            if (!trickle) fifo_push(w);
        end
        start_adr  = sa;
        buf_size   = 32'(bufsz);
        burst_size = 32'(bs);
        enable     = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge wb_clk_i);
            #2;
            if (trickle && wbm_cyc_o && !prev_cyc) check_eq("wait_fill", fifo_cnt >= 4, 1);
            prev_cyc = wbm_cyc_o;
            if (trickle && pushed < nwords && (c % 3) == 0) begin
                fifo_push(words[pushed]);
                pushed++;
            end
            if (done) dones++;
            if ((exp_done > 0 && dones == exp_done) || (err_k != 0 && err)) begin
                enable   = 1'b0;
                finished = 1'b1;
                break;
            end
        end
        check_eq("xfer_timeout", finished, 1);
        check_eq("cyc_dropped", wbm_cyc_o, 0);
        check_eq("err_flag", err, (err_k != 0));
        repeat (3) begin
            @(negedge wb_clk_i);
            #2;
            if (done) dones++;
        end
        check_eq("done_count", dones, exp_done);
        check_eq("busy_idle", busy, 0);
        check_eq("pop_count", n_pops, exp_pops);
        check_eq("sb_left", sb.size(), nwords - exp_pops);
        for (int i = (exp_pops > bufsz ? exp_pops - bufsz : 0); i < exp_pops; i++) begin
            j = i % bufsz;
            check_eq("mem_word", mem.exists(sa + 32'(4 * j)) ? mem[sa + 32'(4 * j)] : 32'hDEAD_BEEF,
                     words[i]);
        end
        fifo_q.delete();
        fifo_update();
        sb.delete();
        mem.delete();
        rty_at = 0;
        err_at = 0;
    endtask

    initial begin
        int seen;
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #2;
        check_eq("rst_cyc", wbm_cyc_o, 0);
        check_eq("rst_stb", wbm_stb_o, 0);
        check_eq("rst_fifo_rd", fifo_rd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_adr", wbm_adr_o, 0);
        check_eq("rst_cti", wbm_cti_o, 0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        #2;

        // two 4-beat bursts, then 4+1, then trickle fill
        run_xfer(32'h1000, 8, 4, 8, 1'b0, 1, 8, 0, 0);
        run_xfer(32'h2000, 5, 4, 5, 1'b0, 1, 5, 0, 0);
        run_xfer(32'h3000, 8, 4, 8, 1'b1, 1, 8, 0, 0);
        // retry on beat 2, error on beat 3
        run_xfer(32'h4000, 4, 4, 4, 1'b0, 1, 4, 2, 0);
        run_xfer(32'h4100, 4, 4, 4, 1'b0, 0, 2, 0, 3);
        // burst_size 0 means single beats; also shows err cleared on restart
        run_xfer(32'hFFFF_FFFC, 2, 0, 2, 1'b0, 1, 2, 0, 0);

        // buf_size 0 never starts
        buf_size = '0;
        enable   = 1'b1;
        seen     = 0;
        repeat (6) begin
            @(negedge wb_clk_i);
            #2;
            if (done || busy || wbm_cyc_o) seen++;
        end
        enable = 1'b0;
        check_eq("bufsz0_idle", seen, 0);

`ifdef WB_STREAM_READER_CIRCULAR_EN
        run_xfer(32'h6000, 4, 4, 12, 1'b0, 3, 12, 0, 0);
`endif

        // reset in the middle of a stalled burst
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) fifo_push($urandom);
        start_adr  = 32'h5000;
        buf_size   = 32'd4;
        burst_size = 32'd4;
        enable     = 1'b1;
        seen       = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge wb_clk_i);
            #2;
            if (wbm_cyc_o) begin
                seen = 1;
                break;
            end
        end
        check_eq("rstmid_cyc_started", seen, 1);
        wb_rst_i = 1'b1;
        enable   = 1'b0;
        @(negedge wb_clk_i);
        #2;
        check_eq("rstmid_cyc", wbm_cyc_o, 0);
        check_eq("rstmid_stb", wbm_stb_o, 0);
        check_eq("rstmid_fifo_rd", fifo_rd, 0);
        check_eq("rstmid_busy", busy, 0);
        wb_rst_i = 1'b0;
        ack_en   = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        #2;
        check_eq("rstmid_stays_idle", wbm_cyc_o, 0);
        check_eq("rstmid_fifo_kept", fifo_cnt, 4);
        fifo_q.delete();
        fifo_update();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
